// File: rtl/uart_stream_rx.sv
// UART 8N1 receiver that delivers each byte through a one-deep valid/ready holding register.
// Optional even parity bit between the data bits and the stop bit: define UART_STREAM_RX_PARITY_EN.
module uart_stream_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       io_clock,
    input  logic       io_reset,
    input  logic       io_rxd,
    output logic [7:0] io_data,
    output logic       io_valid,
    input  logic       io_ready,
    output logic       io_frameError,
    output logic       io_overrun,
    output logic       io_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_STREAM_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rxState_t;

    logic             rxSync_p0;
    logic             rxSync_p1;
    logic             rxsPrev_p2;
    logic             rxs;
    rxState_t         state;
    logic [CNT_W-1:0] bitCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             sampleNow;
    logic             byteDone;
    logic             frameErrNow;

`ifdef UART_STREAM_RX_PARITY_EN
    logic parityErr;

    function automatic logic evenParityOk(input logic [7:0] dataBits, input logic parityBit);
        return ~^{dataBits, parityBit};
    endfunction
`endif

    // Stage p0/p1: two-flop synchroniser for the asynchronous line; p2: previous value for edge detection
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            rxSync_p0  <= 1'b1;
            rxSync_p1  <= 1'b1;
            rxsPrev_p2 <= 1'b1;
        end else begin
            rxSync_p0  <= io_rxd;
            rxSync_p1  <= rxSync_p0;
            rxsPrev_p2 <= rxSync_p1;
        end
    end

    assign rxs       = rxSync_p1;
    assign sampleNow = (bitCnt == '0);
    assign io_busy   = (state != IDLE);

    always_comb begin
        byteDone    = 1'b0;
        frameErrNow = 1'b0;
        if (state == STOP && sampleNow) begin
`ifdef UART_STREAM_RX_PARITY_EN
            byteDone    = rxs && !parityErr;
            frameErrNow = !rxs || parityErr;
`else
            byteDone    = rxs;
            frameErrNow = !rxs;
`endif
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
`ifdef UART_STREAM_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rxsPrev_p2 && !rxs) begin
                        state  <= START;
                        bitCnt <= HALF_LOAD;
                    end
                end
                START: begin
                    if (sampleNow) begin
                        // A line that is high again at mid start bit was only a glitch
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state  <= DATA;
                            bitCnt <= FULL_LOAD;
                            bitIdx <= '0;
                        end
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (sampleNow) begin
                        shiftReg <= {rxs, shiftReg[7:1]};
                        bitCnt   <= FULL_LOAD;
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_STREAM_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
`ifdef UART_STREAM_RX_PARITY_EN
                PARITY: begin
                    if (sampleNow) begin
                        parityErr <= !evenParityOk(shiftReg, rxs);
                        bitCnt    <= FULL_LOAD;
                        state     <= STOP;
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (sampleNow) begin
                        // A low stop bit may be a break; wait for the line to recover before re-arming
                        state <= rxs ? IDLE : WAIT_IDLE;
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            io_data       <= 8'h00;
            io_valid      <= 1'b0;
            io_frameError <= 1'b0;
            io_overrun    <= 1'b0;
        end else begin
            io_frameError <= frameErrNow;
            io_overrun    <= 1'b0;
            if (byteDone) begin
                // The held byte wins; a new byte only lands if the slot is free or draining now
                if (!io_valid || io_ready) begin
                    io_data  <= shiftReg;
                    io_valid <= 1'b1;
                end else begin
                    io_overrun <= 1'b1;
                end
            end else if (io_valid && io_ready) begin
                io_valid <= 1'b0;
            end
        end
    end

endmodule
